apb_gpio_bank: RTL and testbench
================================

// Module: apb_gpio_bank
// PURPOSE
//  APB slave holding one DATA_WIDTH-bit GPIO bank; sits downstream of the SPI-to-APB bridge, one instance per b_psel bit.
//  Provides direction, output, set/clear, synchronized input and edge interrupts, and drives pready back to the bridge.
//  Zero-wait-state APB access; all state in one clock domain (bridge b_pclk).
// PARAMETERS
//  DATA_WIDTH   8  pins per bank; width of pwdata/prdata
//  ADDR_WIDTH   3  register address width (8 registers)
//  SYNC_STAGES  2  flops in the gpio_in synchronizer (>=2)
// PORTS
//  pclk      in   1           APB clock (bridge b_pclk); all logic on rising edge
//  presetn   in   1           asynchronous active-low reset (bridge b_presetn)
//  psel      in   1           bank select (one bit of bridge b_psel)
//  penable   in   1           APB access phase
//  pwrite    in   1           1=write, 0=read
//  paddr     in   ADDR_WIDTH  register index
//  pwdata    in   DATA_WIDTH  write data
//  prdata    out  DATA_WIDTH  read data (to bridge b_prdata)
//  pready    out  1           transfer complete (to bridge b_pready)
//  gpio_in   in   DATA_WIDTH  asynchronous pad inputs
//  gpio_out  out  DATA_WIDTH  pad output values (= OUT reg)
//  gpio_oe   out  DATA_WIDTH  pad output enables (= DIR reg, 1=drive)
//  irq       out  1           level interrupt, |(STAT & IEN)
// BEHAVIOUR
//  Reset: all registers, prdata, pready, irq, gpio_out, gpio_oe = 0; sync/edge flops = 0. Async assert, sync-style release.
//  Register map (paddr): 0 DIR rw | 1 OUT rw | 2 IN ro | 3 IEN rw | 4 IPOL rw (0=rising,1=falling)
//   | 5 STAT rw1c | 6 OUTSET wo, reads 0 | 7 OUTCLR wo, reads 0.
//  FSM IDLE->SETUP->ACCESS->IDLE:
//   IDLE: psel&!penable -> SETUP; penable without prior setup is ignored (no pready, no write).
//   SETUP (psel&!penable): registers pready<=1 and prdata<=reg[paddr] (reads) for the next cycle -> ACCESS.
//   ACCESS (psel&penable&pready): writes commit on this edge; pready<=0, prdata holds; -> IDLE, or SETUP if
//   psel&!penable persists (back-to-back). psel dropped in SETUP -> IDLE, no write, pready<=0.
//  pready high exactly one cycle per transfer, coincident with penable; 1 cycle setup + 1 cycle access.
//  Writes: DIR/OUT/IEN/IPOL <= pwdata; OUTSET: OUT|=pwdata; OUTCLR: OUT&=~pwdata; STAT: STAT&=~pwdata; IN: ignored.
//  Input path: SYNC_STAGES flops then one history flop; IN reg = last sync stage (latency SYNC_STAGES cycles).
//  Edge: rise = s&~h, fall = ~s&h; hit = (IPOL? fall: rise) & ~DIR & IEN; STAT |= hit each cycle.
//  Simultaneous set and W1C on same bit in same cycle: set wins (STAT bit stays 1).
//  Changing DIR/IPOL/IEN never synthesizes an edge; only real transitions of synchronized input set STAT.
//  irq registered: irq <= |(STAT_next & IEN); clearing IEN drops irq next cycle, STAT kept.
//  Read data is sampled in SETUP; a STAT set in ACCESS cycle appears on next read.
//  Reset mid-transfer: everything returns to reset values immediately; the transfer is lost, pready=0.
// STRUCTURE
//  gpio_regs.vh: register index localparams (GPIO_DIR..GPIO_OUTCLR), FSM state encodings.
//  Sub-module gpio_in_sync: SYNC_STAGES synchronizer + history flop, outputs sync/rise/fall vectors.
//  Top holds APB FSM, register file, read mux, irq logic.
// TESTING
//  Reset: pulse presetn low mid-cycle -> all outputs 0 within same cycle, pready 0.
//  Write DIR=8'hF0, OUT=8'hA5, read back -> prdata 8'hF0 / 8'hA5, gpio_oe=F0, gpio_out=A5, pready 1 cycle each.
//  OUT=8'h0F, OUTSET 8'h30, OUTCLR 8'h01 -> gpio_out=8'h3E; reads of addr 6/7 return 8'h00.
//  DIR=0, IEN=8'h01, IPOL=0, gpio_in[0] 0->1 -> STAT=8'h01 and irq=1 by SYNC_STAGES+2 cycles; W1C 8'h01 -> irq 0.
//  IPOL=8'h02, IEN=8'h02, drop gpio_in[1] in the cycle a W1C to STAT bit1 commits -> STAT[1] stays 1, irq stays 1.
//  psel dropped after SETUP with pwrite=1 to OUT -> OUT unchanged, pready never asserts; penable-only cycle ignored.

Source files
------------

// File: rtl/apb_gpio_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_gpio_bank_pkg
// Brief    : Register indices and APB phase encodings shared by the GPIO bank.
// Revision : 1.0 - initial release
// ============================================================================
package apb_gpio_bank_pkg;

  // Register map (paddr index)
  localparam int unsigned GPIO_DIR    = 0;
  localparam int unsigned GPIO_OUT    = 1;
  localparam int unsigned GPIO_IN     = 2;
  localparam int unsigned GPIO_IEN    = 3;
  localparam int unsigned GPIO_IPOL   = 4;
  localparam int unsigned GPIO_STAT   = 5;
  localparam int unsigned GPIO_OUTSET = 6;
  localparam int unsigned GPIO_OUTCLR = 7;

  // APB phase encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

endpackage : apb_gpio_bank_pkg
`default_nettype wire

// File: rtl/apb_gpio_bank_in_sync.sv
`default_nettype none
// ============================================================================
// Module   : apb_gpio_bank_in_sync
// Brief    : Pad input synchronizer plus one history stage; emits the
//            synchronized value and per-bit rising / falling edge strobes.
// Revision : 1.0 - initial release
// ============================================================================
module apb_gpio_bank_in_sync #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  pclk_i,
  input  logic                  presetn_i,
  input  logic [DATA_WIDTH-1:0] gpio_i,
  output logic [DATA_WIDTH-1:0] sync_o,
  output logic [DATA_WIDTH-1:0] rise_o,
  output logic [DATA_WIDTH-1:0] fall_o
);

  logic [DATA_WIDTH-1:0] stage_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] hist_q;

  // Shift the pad value through the synchronizer chain, then into the history flop
  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= '0;
      end
      hist_q <= '0;
    end else begin
      stage_q[0] <= gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
      hist_q <= stage_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = stage_q[SYNC_STAGES-1];
  assign rise_o = sync_o & ~hist_q;
  assign fall_o = ~sync_o & hist_q;

endmodule : apb_gpio_bank_in_sync
`default_nettype wire

// File: rtl/apb_gpio_bank.sv
`default_nettype none
// ============================================================================
// Module   : apb_gpio_bank
// Brief    : Zero-wait-state APB slave for one GPIO bank: direction, output,
//            set/clear, synchronized input and edge-triggered interrupts.
// Revision : 1.0 - initial release
// ============================================================================
module apb_gpio_bank
  import apb_gpio_bank_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  input  logic [DATA_WIDTH-1:0] gpio_in,
  output logic [DATA_WIDTH-1:0] gpio_out,
  output logic [DATA_WIDTH-1:0] gpio_oe,
  output logic                  irq
);

  // state_q records the phase the bus is expected to be in next cycle
  logic [1:0]            state_q, state_d;
  logic [1:0]            w_phase;
  logic                  pready_q, pready_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [DATA_WIDTH-1:0] dir_q, dir_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic [DATA_WIDTH-1:0] ien_q, ien_d;
  logic [DATA_WIDTH-1:0] ipol_q, ipol_d;
  logic [DATA_WIDTH-1:0] stat_q, stat_d;
  logic                  irq_q, irq_d;
  logic [DATA_WIDTH-1:0] w_rdata, w_clr, w_hit;
  logic [DATA_WIDTH-1:0] w_sync, w_rise, w_fall;
  logic [31:0]           w_addr;

  assign w_addr = 32'(paddr);

  apb_gpio_bank_in_sync #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_in_sync (
    .pclk_i    (pclk),
    .presetn_i (presetn),
    .gpio_i    (gpio_in),
    .sync_o    (w_sync),
    .rise_o    (w_rise),
    .fall_o    (w_fall)
  );

  // Classify the current bus cycle; an access phase only counts after our own setup
  always_comb begin
    w_phase = ST_IDLE;
    if (psel && !penable) begin
      w_phase = ST_SETUP;
    end else if (psel && penable && (state_q == ST_ACCESS)) begin
      w_phase = ST_ACCESS;
    end
  end

  // Read mux over the current register contents
  always_comb begin
    w_rdata = '0;
    case (w_addr)
      GPIO_DIR:  w_rdata = dir_q;
      GPIO_OUT:  w_rdata = out_q;
      GPIO_IN:   w_rdata = w_sync;
      GPIO_IEN:  w_rdata = ien_q;
      GPIO_IPOL: w_rdata = ipol_q;
      GPIO_STAT: w_rdata = stat_q;
      default:   w_rdata = '0;
    endcase
  end

  // APB handshake: setup arms pready and captures read data for the access cycle
  always_comb begin
    state_d  = ST_IDLE;
    pready_d = 1'b0;
    prdata_d = prdata_q;
    case (w_phase)
      ST_SETUP: begin
        state_d  = ST_ACCESS;
        pready_d = 1'b1;
        if (!pwrite) begin
          prdata_d = w_rdata;
        end
      end
      default: ;
    endcase
  end

  // Register writes commit on the access edge; edge hits are OR'd in after W1C so sets win
  always_comb begin
    dir_d  = dir_q;
    out_d  = out_q;
    ien_d  = ien_q;
    ipol_d = ipol_q;
    w_clr  = '0;
    if ((w_phase == ST_ACCESS) && pwrite) begin
      case (w_addr)
        GPIO_DIR:    dir_d  = pwdata;
        GPIO_OUT:    out_d  = pwdata;
        GPIO_IEN:    ien_d  = pwdata;
        GPIO_IPOL:   ipol_d = pwdata;
        GPIO_STAT:   w_clr  = pwdata;
        GPIO_OUTSET: out_d  = out_q | pwdata;
        GPIO_OUTCLR: out_d  = out_q & ~pwdata;
        default: ;
      endcase
    end
    w_hit  = ((ipol_q & w_fall) | (~ipol_q & w_rise)) & ~dir_q & ien_q;
    stat_d = (stat_q & ~w_clr) | w_hit;
    irq_d  = |(stat_d & ien_d);
  end

  // State and register file update
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q  <= ST_IDLE;
      pready_q <= 1'b0;
      prdata_q <= '0;
      dir_q    <= '0;
      out_q    <= '0;
      ien_q    <= '0;
      ipol_q   <= '0;
      stat_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pready_q <= pready_d;
      prdata_q <= prdata_d;
      dir_q    <= dir_d;
      out_q    <= out_d;
      ien_q    <= ien_d;
      ipol_q   <= ipol_d;
      stat_q   <= stat_d;
      irq_q    <= irq_d;
    end
  end

  // pready is only presented while the master is actually in its access phase
  assign pready   = pready_q & psel & penable;
  assign prdata   = prdata_q;
  assign irq      = irq_q;
  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;

endmodule : apb_gpio_bank
`default_nettype wire

// File: tb/tb_apb_gpio_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_gpio_bank
// Brief    : Directed self-checking bench for apb_gpio_bank.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_gpio_bank;

  logic       pclk = 1'b0;
  logic       presetn;
  logic       psel, penable, pwrite;
  logic [2:0] paddr;
  logic [7:0] pwdata, prdata;
  logic       pready;
  logic [7:0] gpio_in, gpio_out, gpio_oe;
  logic       irq;

  int total = 0;
  int bad   = 0;

  always #5 pclk = ~pclk;

  apb_gpio_bank #(
    .DATA_WIDTH  (8),
    .ADDR_WIDTH  (3),
    .SYNC_STAGES (2)
  ) dut (
    .pclk     (pclk),
    .presetn  (presetn),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .irq      (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete APB transfer; starts mid-cycle and ends mid-cycle
  task automatic xfer(input logic wr, input logic [2:0] a, input logic [7:0] d, output logic [7:0] rd);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    #1;
    check("pready_setup", {31'd0, pready}, 32'd0);
    @(posedge pclk); #1;
    penable = 1'b1;
    #1;
    check("pready_access", {31'd0, pready}, 32'd1);
    rd = prdata;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    #1;
    check("pready_after", {31'd0, pready}, 32'd0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    logic [7:0] dummy;
    xfer(1'b1, a, d, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] v;
    xfer(1'b0, a, 8'h00, v);
    check(tag, {24'd0, v}, {24'd0, exp});
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 3'd0; pwdata = 8'h00; gpio_in = 8'h00;

    // Reset state
    wait_cycles(2);
    check("rst_prdata", {24'd0, prdata}, 32'h0);
    check("rst_pready", {31'd0, pready}, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    check("rst_gpio_out", {24'd0, gpio_out}, 32'h0);
    check("rst_gpio_oe", {24'd0, gpio_oe}, 32'h0);
    presetn = 1'b1;
    wait_cycles(1);

    // DIR / OUT write and read back
    wr(3'd0, 8'hF0);
    wr(3'd1, 8'hA5);
    rd_chk("rd_dir", 3'd0, 8'hF0);
    rd_chk("rd_out", 3'd1, 8'hA5);
    check("gpio_oe_f0", {24'd0, gpio_oe}, 32'hF0);
    check("gpio_out_a5", {24'd0, gpio_out}, 32'hA5);

    // OUTSET / OUTCLR
    wr(3'd1, 8'h0F);
    wr(3'd6, 8'h30);
    wr(3'd7, 8'h01);
    check("gpio_out_3e", {24'd0, gpio_out}, 32'h3E);
    rd_chk("rd_outset", 3'd6, 8'h00);
    rd_chk("rd_outclr", 3'd7, 8'h00);
    rd_chk("rd_out_3e", 3'd1, 8'h3E);

    // Reset asserted mid-cycle during an access phase
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd0; pwdata = 8'h77;
    @(posedge pclk); #1;
    penable = 1'b1;
    #1;
    check("mid_pready_before", {31'd0, pready}, 32'd1);
    #1;
    presetn = 1'b0;
    #1;
    check("mid_pready", {31'd0, pready}, 32'd0);
    check("mid_gpio_out", {24'd0, gpio_out}, 32'h0);
    check("mid_gpio_oe", {24'd0, gpio_oe}, 32'h0);
    check("mid_irq", {31'd0, irq}, 32'h0);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    wait_cycles(1);
    presetn = 1'b1;
    wait_cycles(1);
    check("mid_write_lost", {24'd0, gpio_oe}, 32'h0);

    // Rising edge interrupt on bit 0
    wr(3'd3, 8'h01);
    wr(3'd4, 8'h00);
    gpio_in = 8'h01;
    wait_cycles(4);
    check("rise_irq", {31'd0, irq}, 32'd1);
    rd_chk("rise_stat", 3'd5, 8'h01);
    rd_chk("rise_in", 3'd2, 8'h01);
    wr(3'd5, 8'h01);
    check("w1c_irq", {31'd0, irq}, 32'd0);
    rd_chk("w1c_stat", 3'd5, 8'h00);

    // Falling polarity on bit 1; rising edge must not set status
    wr(3'd4, 8'h02);
    wr(3'd3, 8'h02);
    gpio_in = 8'h03;
    wait_cycles(4);
    rd_chk("fall_pol_rise_ignored", 3'd5, 8'h00);
    gpio_in = 8'h01;
    wait_cycles(4);
    check("fall_irq", {31'd0, irq}, 32'd1);
    rd_chk("fall_stat", 3'd5, 8'h02);
    gpio_in = 8'h03;
    wait_cycles(4);

    // New falling edge lands on the W1C commit edge: set wins
    gpio_in = 8'h01;
    wait_cycles(1);
    wr(3'd5, 8'h02);
    check("setwins_irq", {31'd0, irq}, 32'd1);
    rd_chk("setwins_stat", 3'd5, 8'h02);

    // Clearing IEN drops irq but keeps STAT
    wr(3'd3, 8'h00);
    check("ien_clr_irq", {31'd0, irq}, 32'd0);
    rd_chk("ien_clr_stat", 3'd5, 8'h02);
    wr(3'd5, 8'h02);
    rd_chk("stat_cleared", 3'd5, 8'h00);

    // Aborted setup and orphan access phase must not write
    wr(3'd1, 8'h5A);
    check("out_5a", {24'd0, gpio_out}, 32'h5A);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd1; pwdata = 8'hFF;
    @(posedge pclk); #1;
    psel = 1'b0;
    #1;
    check("abort_pready", {31'd0, pready}, 32'd0);
    wait_cycles(1);
    check("abort_out", {24'd0, gpio_out}, 32'h5A);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 3'd1; pwdata = 8'hFF;
    #1;
    check("orphan_pready", {31'd0, pready}, 32'd0);
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    #1;
    check("orphan_out", {24'd0, gpio_out}, 32'h5A);
    rd_chk("orphan_rd_out", 3'd1, 8'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_apb_gpio_bank
`default_nettype wire
